multi_uart_rx_aggregator: RTL and testbench

//  N-channel UART receiver. One serial RX line per GPIO-attached peripheral (WiFi, BT, GPS, ...).

---
 rtl/multi_uart_rx_aggregator.sv | 276 +++++++++++++++++++++++++++
 tb/tb_multi_uart_rx_aggregator.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_uart_rx_aggregator.sv
// ---------------------------------------------------------------------------
// multi_uart_rx_aggregator
//
// N-channel UART receiver. Each rxd line has its own 2-FF synchroniser,
// RX state machine and byte FIFO. A round-robin arbiter merges the FIFOs into
// one valid/ready byte stream tagged with the source channel index.
//
// Parameters
//   N_CH          number of UART channels (1..8)
//   CLKS_PER_BIT  clk cycles per bit, >= 8
//   FIFO_DEPTH    bytes per channel FIFO, power of 2, >= 2
//
// Ports
//   clk          system clock
//   reset_n      asynchronous reset, active low
//   rxd          serial inputs, idle high, bit i = channel i
//   out_valid    out_data/out_ch hold a byte
//   out_ready    sink accepts the byte when out_valid is also high
//   out_data     received byte
//   out_ch       source channel of out_data
//   overflow     sticky per channel: byte dropped because the FIFO was full
//   framing_err  sticky per channel: bad stop bit (or bad parity)
//   clear_err    pulse: clears overflow and framing_err
//
// Configuration macro
//   UART_PARITY_EN  defined   -> 8E1 frames, parity error reported as framing_err
//                   undefined -> 8N1 frames, no parity logic
// ---------------------------------------------------------------------------
module multi_uart_rx_aggregator #(
  parameter int N_CH         = 3,
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] rxd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      out_data,
  output logic [CH_W-1:0] out_ch,
  output logic [N_CH-1:0] overflow,
  output logic [N_CH-1:0] framing_err,
  input  logic            clear_err
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // Counters run down to zero, so a reload of K means K+1 cycles until the
  // next sample.
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  // Per-channel FIFO status seen by the arbiter.
  logic [N_CH-1:0] fifo_empty;
  logic [N_CH-1:0] pop;
  logic [7:0]      head [N_CH];

  // Arbiter state and decision.
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] grant_idx;
  logic [CH_W-1:0] rr_next;
  logic            grant_valid;
  logic            load;
  int              cand;

  // The output register may take a new byte when it is empty or is being
  // emptied by a handshake this cycle; this is what sustains one byte/cycle.
  assign load = !out_valid || out_ready;

  // First non-empty FIFO starting at rr_ptr, wrapping modulo N_CH.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < N_CH; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_CH) cand = cand - N_CH;
      if (!grant_valid && !fifo_empty[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = CH_W'(cand);
      end
    end
  end

  always_comb begin
    pop = '0;
    if (load && grant_valid) pop[grant_idx] = 1'b1;
  end

  assign rr_next = (int'(grant_idx) == N_CH - 1) ? '0 : grant_idx + CH_W'(1);

  // Output register. Holds its contents while out_valid && !out_ready.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= grant_valid;
      if (grant_valid) begin
        out_data <= head[grant_idx];
        out_ch   <= grant_idx;
        rr_ptr   <= rr_next;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             sync1, sync2, sync_prev;
    logic [2:0]       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic             push_q;
    logic             stop_done;
    logic             frame_bad;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             full;
    logic             do_write;
    logic             ovf_q, ferr_q;

    assign stop_done = (state == S_STOP) && (baud_cnt == '0);

`ifdef UART_PARITY_EN
    logic parity_bad;
    assign frame_bad = !sync2 || parity_bad;
`else
    assign frame_bad = !sync2;
`endif

    // Synchroniser, edge detector and RX state machine. The synchroniser
    // resets to idle-high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1     <= 1'b1;
        sync2     <= 1'b1;
        sync_prev <= 1'b1;
        state     <= S_IDLE;
        baud_cnt  <= '0;
        bit_cnt   <= '0;
        shift     <= '0;
        push_q    <= 1'b0;
`ifdef UART_PARITY_EN
        parity_bad <= 1'b0;
`endif
      end else begin
        sync1     <= rxd[i];
        sync2     <= sync1;
        sync_prev <= sync2;
        push_q    <= 1'b0;
        case (state)
          // Only a fresh 1->0 edge starts a frame; a line stuck low does not.
          S_IDLE: begin
            if (sync_prev && !sync2) begin
              state    <= S_START;
              baud_cnt <= HALF_RELOAD;
            end
          end
          // Mid start bit: a line back high was a glitch, drop it silently.
          S_START: begin
            if (baud_cnt != '0) begin
              baud_cnt <= baud_cnt - CNT_W'(1);
            end else if (!sync2) begin
              state    <= S_DATA;
              baud_cnt <= BIT_RELOAD;
              bit_cnt  <= '0;
`ifdef UART_PARITY_EN
              parity_bad <= 1'b0;
`endif
            end else begin
              state <= S_IDLE;
            end
          end
          S_DATA: begin
            if (baud_cnt != '0) begin
              baud_cnt <= baud_cnt - CNT_W'(1);
            end else begin
              shift    <= {sync2, shift[7:1]};
              baud_cnt <= BIT_RELOAD;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
`ifdef UART_PARITY_EN
                state <= S_PARITY;
`else
                state <= S_STOP;
`endif
              end
            end
          end
`ifdef UART_PARITY_EN
          // Even parity: the eight data bits plus this bit hold an even
          // number of ones.
          S_PARITY: begin
            if (baud_cnt != '0) begin
              baud_cnt <= baud_cnt - CNT_W'(1);
            end else begin
              parity_bad <= ^{shift, sync2};
              baud_cnt   <= BIT_RELOAD;
              state      <= S_STOP;
            end
          end
`endif
          // shift is untouched in IDLE, so the push one cycle later still
          // sees the assembled byte.
          S_STOP: begin
            if (baud_cnt != '0) begin
              baud_cnt <= baud_cnt - CNT_W'(1);
            end else begin
              state  <= S_IDLE;
              push_q <= !frame_bad;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end

    // FIFO with one extra pointer bit to tell full from empty.
    assign full          = (wr_ptr[AW] != rd_ptr[AW]) &&
                           (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign fifo_empty[i] = (wr_ptr == rd_ptr);
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still succeeds then.
    assign do_write      = push_q && (!full || pop[i]);
    assign head[i]       = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_write) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])   rd_ptr <= rd_ptr + 1'b1;
      end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr[AW-1:0]] <= shift;
    end

    // Sticky flags: a set event beats a simultaneous clear.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        ovf_q  <= 1'b0;
        ferr_q <= 1'b0;
      end else begin
        if (push_q && full && !pop[i]) ovf_q <= 1'b1;
        else if (clear_err)            ovf_q <= 1'b0;
        if (stop_done && frame_bad)    ferr_q <= 1'b1;
        else if (clear_err)            ferr_q <= 1'b0;
      end
    end

    assign overflow[i]    = ovf_q;
    assign framing_err[i] = ferr_q;
  end

endmodule

// File: tb/tb_multi_uart_rx_aggregator.sv
// ---------------------------------------------------------------------------
// Testbench for multi_uart_rx_aggregator (N_CH=3, CLKS_PER_BIT=8, FIFO_DEPTH=4).
// A reference model keeps, per channel, the queue of bytes that must come out
// in order. One compare process checks every handshake against it and that
// the output holds still while stalled; directed tests add literal checks.
// ---------------------------------------------------------------------------
module tb_multi_uart_rx_aggregator;

  localparam int N_CH  = 3;
  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int CH_W  = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N_CH-1:0] rxd = '1;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [7:0]      out_data;
  logic [CH_W-1:0] out_ch;
  logic [N_CH-1:0] overflow;
  logic [N_CH-1:0] framing_err;
  logic            clear_err = 1'b0;

  multi_uart_rx_aggregator #(
    .N_CH(N_CH), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rxd(rxd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch),
    .overflow(overflow), .framing_err(framing_err),
    .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int         cyc;
    int         ch;
    logic [7:0] data;
  } rec_t;

  logic [7:0] exp_q [N_CH][$];
  rec_t       log_q [$];
  int         frame_start [N_CH];
  int         rise_cyc = -1;
  int         valid_hi_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int c = 0; c < N_CH; c++) s += exp_q[c].size();
    return s;
  endfunction

  // Compare process: runs on the falling edge, away from the active edge.
  logic            hold_prev = 1'b0;
  logic            valid_prev = 1'b0;
  logic [7:0]      hold_data;
  logic [CH_W-1:0] hold_ch;

  always @(negedge clk) begin
    if (!reset_n) begin
      hold_prev  = 1'b0;
      valid_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(hold_data));
        check("stall_ch", 32'(out_ch), 32'(hold_ch));
      end
      if (out_valid && !valid_prev) rise_cyc = cyc;
      if (out_valid) valid_hi_cnt++;
      if (out_valid && out_ready) begin
        if (int'(out_ch) < N_CH && exp_q[out_ch].size() > 0) begin
          check("stream_data", 32'(out_data), 32'(exp_q[out_ch].pop_front()));
        end else begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_byte: got ch=%0d data=0x%02h, required no byte",
                   out_ch, out_data);
        end
        log_q.push_back('{cyc, int'(out_ch), out_data});
      end
      hold_prev  = out_valid && !out_ready;
      hold_data  = out_data;
      hold_ch    = out_ch;
      valid_prev = out_valid;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int c = 0; c < N_CH; c++) exp_q[c].delete();
    log_q.delete();
  endtask

  task automatic reset_dut();
    @(posedge clk); #1;
    reset_n   = 1'b0;
    rxd       = '1;
    out_ready = 1'b0;
    clear_err = 1'b0;
    clear_model();
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(4);
  endtask

  // One frame on channel ch. The model learns the byte when the stop bit
  // starts, i.e. before the DUT can possibly deliver it.
  task automatic send_frame(input int ch, input logic [7:0] d, input bit stop_ok,
                            input bit par_ok, input bit kept);
    @(posedge clk); #1;
    rxd[ch] = 1'b0;
    frame_start[ch] = cyc;
    repeat (CPB) @(posedge clk);
    for (int b = 0; b < 8; b++) begin
      #1 rxd[ch] = d[b];
      repeat (CPB) @(posedge clk);
    end
`ifdef UART_PARITY_EN
    #1 rxd[ch] = (^d) ^ !par_ok;
    repeat (CPB) @(posedge clk);
`endif
    #1 rxd[ch] = stop_ok;
    if (stop_ok && par_ok && kept) exp_q[ch].push_back(d);
    repeat (CPB) @(posedge clk);
    #1 rxd[ch] = 1'b1;
  endtask

  task automatic rand_burst(input int ch, input int n);
    for (int k = 0; k < n; k++) begin
      wait_cycles($urandom_range(0, 20));
      send_frame(ch, 8'($urandom), 1'b1, 1'b1, 1'b1);
    end
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    wait_cycles(1);
    clear_err = 1'b0;
    wait_cycles(1);
  endtask

  bit rand_done;
  int lo;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset_dut();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_framing", 32'(framing_err), 32'd0);

    // Single byte, latency and one-cycle valid
    out_ready    = 1'b1;
    valid_hi_cnt = 0;
    rise_cyc     = -1;
    send_frame(1, 8'hA5, 1'b1, 1'b1, 1'b1);
    wait_cycles(12);
    // Stop bit centre is 9.5 bit times after the start edge; out_valid follows
    // it by 2 clk plus up to 4 clk of synchroniser/edge-detect delay.
    lo = frame_start[1] + 9 * CPB + CPB / 2 + 2;
`ifdef UART_PARITY_EN
    lo = lo + CPB;
`endif
    check("t1_latency_window", 32'(rise_cyc >= lo && rise_cyc <= lo + 4), 32'd1);
    check("t1_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) begin
      check("t1_data", 32'(log_q[0].data), 32'hA5);
      check("t1_ch", 32'(log_q[0].ch), 32'd1);
    end
    check("t1_valid_cycles", 32'(valid_hi_cnt), 32'd1);
    check("t1_flags", 32'({overflow, framing_err}), 32'd0);

    // Simultaneous bytes, round-robin order
    reset_dut();
    fork
      send_frame(0, 8'h11, 1'b1, 1'b1, 1'b1);
      send_frame(1, 8'h22, 1'b1, 1'b1, 1'b1);
      send_frame(2, 8'h33, 1'b1, 1'b1, 1'b1);
    join
    wait_cycles(10);
    check("t2_held_valid", 32'(out_valid), 32'd1);
    check("t2_held_ch", 32'(out_ch), 32'd0);
    out_ready = 1'b1;
    wait_cycles(10);
    check("t2_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      for (int k = 0; k < 3; k++) check("t2_order_ch", 32'(log_q[k].ch), 32'(k));
      check("t2_data0", 32'(log_q[0].data), 32'h11);
      check("t2_data2", 32'(log_q[2].data), 32'h33);
      check("t2_back_to_back", 32'(log_q[2].cyc - log_q[0].cyc), 32'd2);
    end

    // Overflow: output register + DEPTH FIFO entries, the next byte drops
    reset_dut();
    for (int k = 0; k < 6; k++)
      send_frame(2, 8'(k + 1), 1'b1, 1'b1, k < DEPTH + 1);
    wait_cycles(10);
    check("t3_overflow", 32'(overflow), 32'b100);
    check("t3_framing", 32'(framing_err), 32'd0);
    check("t3_reg_data", 32'(out_data), 32'h01);
    out_ready = 1'b1;
    wait_cycles(20);
    check("t3_count", 32'(log_q.size()), 32'd5);
    if (log_q.size() == 5)
      for (int k = 0; k < 5; k++) check("t3_order", 32'(log_q[k].data), 32'(k + 1));
    check("t3_overflow_kept", 32'(overflow), 32'b100);
    pulse_clear();
    check("t3_overflow_cleared", 32'(overflow), 32'd0);

    // Framing error, then a clean byte
    reset_dut();
    out_ready = 1'b1;
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1);
    wait_cycles(10);
    check("t4_framing", 32'(framing_err), 32'b001);
    check("t4_no_output", 32'(log_q.size()), 32'd0);
    wait_cycles(5);
    send_frame(0, 8'h66, 1'b1, 1'b1, 1'b1);
    wait_cycles(10);
    check("t4_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() == 1) check("t4_data", 32'(log_q[0].data), 32'h66);
    check("t4_framing_sticky", 32'(framing_err), 32'b001);

    // Start-bit glitch shorter than half a bit
    reset_dut();
    out_ready = 1'b1;
    rxd[1] = 1'b0;
    wait_cycles(2);
    rxd[1] = 1'b1;
    wait_cycles(40);
    check("t5_no_output", 32'(log_q.size() + int'(out_valid)), 32'd0);
    check("t5_no_flags", 32'({overflow, framing_err}), 32'd0);
    send_frame(1, 8'h7E, 1'b1, 1'b1, 1'b1);
    wait_cycles(10);
    check("t5_recovered", 32'(log_q.size()), 32'd1);

    // Reset mid-frame
    reset_dut();
    send_frame(1, 8'h9A, 1'b1, 1'b1, 1'b1);
    send_frame(2, 8'h42, 1'b0, 1'b1, 1'b1);
    wait_cycles(5);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    check("t6_pre_framing", 32'(framing_err), 32'b100);
    rxd[0] = 1'b0;
    wait_cycles(3 * CPB + 2);
    rxd[0] = 1'b1;
    wait_cycles(CPB);
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_outputs", 32'({out_valid, out_data, out_ch, overflow, framing_err}), 32'd0);
    clear_model();
    rxd = '1;
    wait_cycles(3);
    reset_n = 1'b1;
    wait_cycles(20);
    check("t6_post_quiet", 32'({out_valid, overflow, framing_err}), 32'd0);
    out_ready = 1'b1;
    send_frame(0, 8'h3C, 1'b1, 1'b1, 1'b1);
    wait_cycles(10);
    check("t6_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() == 1) check("t6_data", 32'(log_q[0].data), 32'h3C);

`ifdef UART_PARITY_EN
    // Bad parity
    reset_dut();
    out_ready = 1'b1;
    send_frame(1, 8'hB7, 1'b1, 1'b0, 1'b1);
    wait_cycles(10);
    check("par_no_output", 32'(log_q.size()), 32'd0);
    check("par_framing", 32'(framing_err), 32'b010);
    send_frame(1, 8'hB7, 1'b1, 1'b1, 1'b1);
    wait_cycles(10);
    check("par_good_count", 32'(log_q.size()), 32'd1);
`endif

    // Randomized traffic on all channels with a random sink
    reset_dut();
    rand_done = 1'b0;
    fork
      begin
        fork
          rand_burst(0, 5);
          rand_burst(1, 5);
          rand_burst(2, 5);
        join
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = 1'($urandom_range(0, 1));
          wait_cycles(1);
        end
      end
    join
    out_ready = 1'b1;
    wait_cycles(20);
    check("rand_all_delivered", 32'(pending()), 32'd0);
    check("rand_count", 32'(log_q.size()), 32'd15);
    check("rand_flags", 32'({overflow, framing_err}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
